// File: rtl/decoder_pkg.sv
// Shared types and constants for the registered 3-to-8 decoder.
// DECODER_3_8_ACTIVE_LOW_EN selects active-low (74x138-style) outputs.
package decoder_pkg;

  localparam int unsigned SEL_W = 3;
  localparam int unsigned OUT_W = 8;

  typedef logic [SEL_W-1:0] sel_t;
  typedef logic [OUT_W-1:0] onehot_t;

  // All outputs inactive: the reset value and the illegal-select value.
`ifdef DECODER_3_8_ACTIVE_LOW_EN
  localparam onehot_t ONEHOT_IDLE = '1;
`else
  localparam onehot_t ONEHOT_IDLE = '0;
`endif

endpackage : decoder_pkg

// File: rtl/onehot_dec.sv
// Combinational binary-to-one-hot decoder; any select that is not 0..7 yields all zeros.
module onehot_dec
  import decoder_pkg::*;
(
  input  sel_t    sel,
  output onehot_t onehot
);

  always_comb begin
    onehot = '0;
    case (sel)
      3'd0:    onehot = 8'h01;
      3'd1:    onehot = 8'h02;
      3'd2:    onehot = 8'h04;
      3'd3:    onehot = 8'h08;
      3'd4:    onehot = 8'h10;
      3'd5:    onehot = 8'h20;
      3'd6:    onehot = 8'h40;
      3'd7:    onehot = 8'h80;
      default: onehot = '0;
    endcase
  end

endmodule : onehot_dec

// File: rtl/decoder_3_to_8.sv
// Registered 3-to-8 one-hot decoder, one cycle latency, all outputs flop-driven.
// Define DECODER_3_8_ACTIVE_LOW_EN for active-low outputs (reset value 8'hFF).
module decoder_3_to_8
  import decoder_pkg::*;
(
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic A0,
  input  logic A1,
  input  logic A2,
  output logic Y0,
  output logic Y1,
  output logic Y2,
  output logic Y3,
  output logic Y4,
  output logic Y5,
  output logic Y6,
  output logic Y7
);

  sel_t    sel;
  onehot_t dec;
  onehot_t y_d;
  onehot_t y_q;

  assign sel = {A2, A1, A0};

  onehot_dec u_onehot_dec (
    .sel    (sel),
    .onehot (dec)
  );

  // Inversion sits ahead of the register so the outputs stay flop-driven.
  always_comb begin
    y_d = dec;
`ifdef DECODER_3_8_ACTIVE_LOW_EN
    y_d = ~dec;
`endif
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) y_q <= ONEHOT_IDLE;
    else            y_q <= y_d;
  end

  assign Y0 = y_q[0];
  assign Y1 = y_q[1];
  assign Y2 = y_q[2];
  assign Y3 = y_q[3];
  assign Y4 = y_q[4];
  assign Y5 = y_q[5];
  assign Y6 = y_q[6];
  assign Y7 = y_q[7];

endmodule : decoder_3_to_8

// File: tb/tb_decoder_3_to_8.sv
// Self-checking bench for decoder_3_to_8; honours DECODER_3_8_ACTIVE_LOW_EN.
module tb_decoder_3_to_8;

  logic sys_clk;
  logic sys_rst_n;
  logic A0, A1, A2;
  logic Y0, Y1, Y2, Y3, Y4, Y5, Y6, Y7;
  logic [7:0] y;

  int unsigned passed;
  int unsigned total;

  typedef struct {
    logic [2:0] sel;
    logic [7:0] y;
  } vec_t;

  vec_t sweep [8];
  vec_t b2b   [4];

  decoder_3_to_8 dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .A0        (A0),
    .A1        (A1),
    .A2        (A2),
    .Y0        (Y0),
    .Y1        (Y1),
    .Y2        (Y2),
    .Y3        (Y3),
    .Y4        (Y4),
    .Y5        (Y5),
    .Y6        (Y6),
    .Y7        (Y7)
  );

  assign y = {Y7, Y6, Y5, Y4, Y3, Y2, Y1, Y0};

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // Map an active-high expectation onto the polarity of this build.
  function automatic logic [7:0] pol(input logic [7:0] oh);
`ifdef DECODER_3_8_ACTIVE_LOW_EN
    return ~oh;
`else
    return oh;
`endif
  endfunction

  task automatic check(input string name, input logic [7:0] exp);
    total++;
    if (y === exp) passed++;
    else $display("FAIL %s: Y7..Y0 = %h, expected %h at %0t", name, y, exp, $time);
  endtask

  task automatic set_sel(input logic [2:0] s);
    {A2, A1, A0} = s;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    passed = 0;
    total  = 0;

    sweep[0] = '{3'b000, 8'h01};
    sweep[1] = '{3'b001, 8'h02};
    sweep[2] = '{3'b010, 8'h04};
    sweep[3] = '{3'b011, 8'h08};
    sweep[4] = '{3'b100, 8'h10};
    sweep[5] = '{3'b101, 8'h20};
    sweep[6] = '{3'b110, 8'h40};
    sweep[7] = '{3'b111, 8'h80};
    b2b[0]   = '{3'b000, 8'h01};
    b2b[1]   = '{3'b111, 8'h80};
    b2b[2]   = '{3'b001, 8'h02};
    b2b[3]   = '{3'b110, 8'h40};

    // Reset held with a live select and a running clock.
    sys_rst_n = 1'b0;
    set_sel(3'b101);
    #1;
    check("reset_initial", pol(8'h00));
    for (int i = 0; i < 3; i++) begin
      @(posedge sys_clk); #1;
      check("reset_hold", pol(8'h00));
    end

    // Explicit active-low spot check value: 011 -> F7 in that build.
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    set_sel(3'b011);
    @(posedge sys_clk); #1;
    check("sel_011", pol(8'h08));

    // Full sweep, each select held two clocks.
    for (int i = 0; i < 8; i++) begin
      @(negedge sys_clk);
      set_sel(sweep[i].sel);
      @(posedge sys_clk); #1;
      check("sweep_first", pol(sweep[i].y));
      @(posedge sys_clk); #1;
      check("sweep_hold", pol(sweep[i].y));
    end

    // Mid-cycle select change must not reach Y before the next edge.
    @(negedge sys_clk);
    set_sel(3'b010);
    @(posedge sys_clk); #1;
    check("glitch_before", pol(8'h04));
    #2;
    set_sel(3'b110);
    #1;
    check("glitch_mid", pol(8'h04));
    @(negedge sys_clk); #1;
    check("glitch_late", pol(8'h04));
    @(posedge sys_clk); #1;
    check("glitch_after", pol(8'h40));

    // Asynchronous reset between edges, then release.
    @(negedge sys_clk);
    set_sel(3'b111);
    @(posedge sys_clk); #1;
    check("arst_pre", pol(8'h80));
    #2;
    sys_rst_n = 1'b0;
    #1;
    check("arst_immediate", pol(8'h00));
    @(posedge sys_clk); #1;
    check("arst_held", pol(8'h00));
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    #1;
    check("arst_released_no_edge", pol(8'h00));
    @(posedge sys_clk); #1;
    check("arst_first_edge", pol(8'h80));

    // Back-to-back select changes every cycle.
    for (int i = 0; i < 4; i++) begin
      @(negedge sys_clk);
      set_sel(b2b[i].sel);
      @(posedge sys_clk); #1;
      check("back_to_back", pol(b2b[i].y));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule : tb_decoder_3_to_8
